// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: iterative radix-2 multiply/divide core for the MDU.
// Produces the 32-bit RISC-V M-extension result selected by opCode from
// two 33-bit conditioned operands.
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   start, opCode  - request and operation; start is taken only while ready
//   operand0       - conditioned multiplicand / divisor (33-bit two's complement)
//   operand1       - conditioned multiplier / dividend (33-bit two's complement)
//   ready          - core is idle and can accept a request
//   resultValid    - one-cycle pulse marking a new result
//   result         - selected result, held until the next resultValid
//   divByZero      - divide by zero flag, qualified by resultValid
module mul_div_sequencer #(
  parameter int unsigned PAR          = 32,
  parameter int unsigned OPCODE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [OPCODE_WIDTH-1:0] opCode,
  input  logic [PAR:0]            operand0,
  input  logic [PAR:0]            operand1,
  output logic                    ready,
  output logic                    resultValid,
  output logic [PAR-1:0]          result,
  output logic                    divByZero
);

  localparam int unsigned CntW = $clog2(PAR + 1);
  localparam logic [CntW-1:0] MulLast = CntW'(PAR);
  localparam logic [CntW-1:0] DivLast = CntW'(PAR - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} stateT;

  stateT                   state, nextState;
  logic [OPCODE_WIDTH-1:0] opReg;
  logic                    neg0, neg1, dz;
  logic [PAR:0]            opA;   // multiplicand, or divisor magnitude
  logic [PAR+1:0]          hi;    // product accumulator, or partial remainder
  logic [PAR:0]            lo;    // multiplier/product low half, or dividend/quotient
  logic [CntW-1:0]         cnt;

  logic           accept, divisorZero, qBit;
  logic [PAR:0]   mag0, mag1, shifted, diff;
  logic [PAR+1:0] mcandExt, addend, sum;
  logic [PAR-1:0] quo, rem, mulRes;

  // Datapath combinational terms for both iteration kinds and the fix-up step
  always_comb begin
    accept      = start & ready;
    divisorZero = (operand0 == '0);
    mag0        = operand0[PAR] ? -operand0 : operand0;
    mag1        = operand1[PAR] ? -operand1 : operand1;
    // Multiplier sign bit carries weight -2^PAR, so the last step subtracts
    mcandExt    = {opA[PAR], opA};
    addend      = '0;
    if (lo[0]) addend = (cnt == MulLast) ? -mcandExt : mcandExt;
    sum         = hi + addend;
    // Restoring step: bring in next dividend bit, keep difference if non-negative
    shifted     = {hi[PAR-1:0], lo[PAR-1]};
    diff        = shifted - opA;
    qBit        = (shifted >= opA);
    quo         = ((neg0 ^ neg1) && !dz) ? -lo[PAR-1:0] : lo[PAR-1:0];
    rem         = (neg1 && !dz) ? -hi[PAR-1:0] : hi[PAR-1:0];
    // After PAR+1 shifts lo holds product[PAR:0] and hi the bits above
    mulRes      = (opReg[1:0] == 2'b00) ? lo[PAR-1:0] : {hi[PAR-2:0], lo[PAR]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = !opCode[2] ? MUL : (divisorZero ? FIX : DIV);
      MUL:  if (cnt == MulLast) nextState = FIX;
      DIV:  if (cnt == DivLast) nextState = FIX;
      FIX:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand latch, iteration registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      opReg       <= '0;
      neg0        <= 1'b0;
      neg1        <= 1'b0;
      dz          <= 1'b0;
      opA         <= '0;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      ready       <= 1'b1;
      resultValid <= 1'b0;
      result      <= '0;
      divByZero   <= 1'b0;
    end else begin
      ready       <= (nextState == IDLE);
      resultValid <= (state == FIX);
      case (state)
        IDLE: if (accept) begin
          opReg <= opCode;
          neg0  <= operand0[PAR];
          neg1  <= operand1[PAR];
          cnt   <= '0;
          dz    <= opCode[2] & divisorZero;
          if (!opCode[2]) begin
            opA <= operand0;
            hi  <= '0;
            lo  <= operand1;
          end else if (divisorZero) begin
            // Preload the architected divide-by-zero quotient and remainder
            opA <= '0;
            hi  <= {2'b00, operand1[PAR-1:0]};
            lo  <= '1;
          end else begin
            opA <= mag0;
            hi  <= '0;
            lo  <= mag1;
          end
        end
        MUL: begin
          hi  <= {sum[PAR+1], sum[PAR+1:1]};
          lo  <= {sum[0], lo[PAR:1]};
          cnt <= cnt + CntW'(1);
        end
        DIV: begin
          hi  <= qBit ? {1'b0, diff} : {1'b0, shifted};
          lo  <= {1'b0, lo[PAR-2:0], qBit};
          cnt <= cnt + CntW'(1);
        end
        FIX: begin
          result    <= !opReg[2] ? mulRes : (opReg[1] ? rem : quo);
          divByZero <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer: directed vectors, randomized
// operations against an arithmetic reference model, handshake and reset cases.
module tb_mul_div_sequencer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  opCode;
  logic [32:0] operand0, operand1;
  logic        ready, resultValid, divByZero;
  logic [31:0] result;

  int checkCnt = 0;
  int passCnt  = 0;

  mul_div_sequencer #(.PAR(32), .OPCODE_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .opCode(opCode),
    .operand0(operand0), .operand1(operand1),
    .ready(ready), .resultValid(resultValid), .result(result), .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {rs1 signed, rs2 signed} for each opcode
  function automatic logic [1:0] signedness(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b100, 3'b110: return 2'b11;
      3'b010:                         return 2'b10;
      default:                        return 2'b00;
    endcase
  endfunction

  function automatic logic [32:0] condOp(input logic [31:0] v, input logic sgn);
    return {sgn & v[31], v};
  endfunction

  // RISC-V M-extension semantics; returns {divByZero, result}
  function automatic logic [32:0] refModel(input logic [2:0] op, input logic [31:0] rs1,
                                           input logic [31:0] rs2);
    logic [1:0] s;
    longint x, y, q, r;
    logic signed [65:0] px, py, p;
    s = signedness(op);
    x = s[1] ? longint'($signed(rs1)) : longint'(rs1);
    y = s[0] ? longint'($signed(rs2)) : longint'(rs2);
    if (!op[2]) begin
      px = x; py = y; p = px * py;
      return {1'b0, (op == 3'b000) ? p[31:0] : p[63:32]};
    end
    if (y == 0) return {1'b1, op[1] ? rs1 : 32'hFFFF_FFFF};
    q = x / y;
    r = x % y;
    return {1'b0, op[1] ? r[31:0] : q[31:0]};
  endfunction

  function automatic int expLat(input logic [2:0] op, input logic [31:0] rs2);
    if (!op[2]) return 35;
    return (rs2 == 0) ? 2 : 34;
  endfunction

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation from idle, scramble inputs after accept, wait for the result
  task automatic runOp(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       output logic [31:0] res, output logic dzOut, output int lat,
                       output logic pulseOk);
    logic [1:0] s;
    logic rdyAtValid;
    s = signedness(op);
    @(posedge clk); #1;
    opCode = op; operand1 = condOp(rs1, s[1]); operand0 = condOp(rs2, s[0]); start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (lat == 1) begin
        start = 1'b0; opCode = 3'($urandom);
        operand0 = {1'($urandom), $urandom}; operand1 = {1'($urandom), $urandom};
      end
    end while (!resultValid && lat < 200);
    res = result; dzOut = divByZero; rdyAtValid = ready;
    @(posedge clk); #1;
    pulseOk = rdyAtValid && !resultValid;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; opCode = '0; operand0 = '0; operand1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkCnt++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else passCnt++;
    checkCnt++; if (resultValid !== 1'b0) $display("FAIL reset_valid: got %b want 0", resultValid); else passCnt++;
    checkCnt++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else passCnt++;
    checkCnt++; if (divByZero !== 1'b0) $display("FAIL reset_dbz: got %b want 0", divByZero); else passCnt++;
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [2:0]  ops [12] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110,
                              3'b101, 3'b111, 3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] a1 [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5,
                             32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] a2 [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex [12] = '{32'hFFFF_FFEB, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                             32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234_5678,
                             32'h8000_0000, 32'h0};
    int          lt [12] = '{35, 35, 35, 35, 34, 34, 34, 34, 2, 2, 34, 34};
    logic        dzx[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    logic [31:0] res; logic d, pOk; int lat;
    for (int i = 0; i < 12; i++) begin
      runOp(ops[i], a1[i], a2[i], res, d, lat, pOk);
      checkCnt++; if (res !== ex[i]) $display("FAIL dir%0d_result: got %h want %h", i, res, ex[i]); else passCnt++;
      checkCnt++; if (lat != lt[i]) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, lt[i]); else passCnt++;
      checkCnt++; if (d !== dzx[i]) $display("FAIL dir%0d_dbz: got %b want %b", i, d, dzx[i]); else passCnt++;
      checkCnt++; if (pOk !== 1'b1) $display("FAIL dir%0d_pulse: got %b want 1", i, pOk); else passCnt++;
    end
  endtask

  task automatic test_random;
    logic [2:0] op; logic [31:0] rs1, rs2, res; logic [32:0] m; logic d, pOk; int lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7)); rs1 = pickVal(); rs2 = pickVal();
      m = refModel(op, rs1, rs2);
      runOp(op, rs1, rs2, res, d, lat, pOk);
      checkCnt++; if (res !== m[31:0]) $display("FAIL rnd%0d_result op=%0d rs1=%h rs2=%h: got %h want %h", i, op, rs1, rs2, res, m[31:0]); else passCnt++;
      checkCnt++; if (d !== m[32]) $display("FAIL rnd%0d_dbz: got %b want %b", i, d, m[32]); else passCnt++;
      checkCnt++; if (lat != expLat(op, rs2)) $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, expLat(op, rs2)); else passCnt++;
    end
  endtask

  task automatic test_busy_start;
    logic [31:0] prev, rs1, rs2; logic [32:0] m; int lat, extra;
    prev = result; rs1 = $urandom; rs2 = $urandom;
    m = refModel(3'b001, rs1, rs2);
    @(posedge clk); #1;
    opCode = 3'b001; operand1 = condOp(rs1, 1'b1); operand0 = condOp(rs2, 1'b1); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; lat = 1;
    repeat (4) begin @(posedge clk); lat++; end
    #1;
    opCode = 3'b100; operand0 = '0; operand1 = 33'd9; start = 1'b1;
    @(posedge clk); #1; lat++; start = 1'b0;
    checkCnt++; if (result !== prev) $display("FAIL busy_held: got %h want %h", result, prev); else passCnt++;
    while (!resultValid && lat < 200) begin @(posedge clk); #1; lat++; end
    checkCnt++; if (lat != 35) $display("FAIL busy_latency: got %0d want 35", lat); else passCnt++;
    checkCnt++; if (result !== m[31:0]) $display("FAIL busy_result: got %h want %h", result, m[31:0]); else passCnt++;
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (resultValid) extra++; end
    checkCnt++; if (extra != 0) $display("FAIL busy_extra_valid: got %0d want 0", extra); else passCnt++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] r1a, r2a, r1b, r2b; logic [32:0] ma, mb; int lat;
    r1a = $urandom; r2a = $urandom; r1b = $urandom; r2b = pickVal();
    ma = refModel(3'b000, r1a, r2a);
    mb = refModel(3'b110, r1b, r2b);
    @(posedge clk); #1;
    opCode = 3'b000; operand1 = condOp(r1a, 1'b1); operand0 = condOp(r2a, 1'b1); start = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!resultValid && lat < 200);
    checkCnt++; if (lat != 35) $display("FAIL b2b_first_latency: got %0d want 35", lat); else passCnt++;
    checkCnt++; if (result !== ma[31:0]) $display("FAIL b2b_first_result: got %h want %h", result, ma[31:0]); else passCnt++;
    checkCnt++; if (ready !== 1'b1) $display("FAIL b2b_ready_with_valid: got %b want 1", ready); else passCnt++;
    opCode = 3'b110; operand1 = condOp(r1b, 1'b1); operand0 = condOp(r2b, 1'b1);
    @(posedge clk); #1; start = 1'b0; lat = 1;
    checkCnt++; if (ready !== 1'b0) $display("FAIL b2b_second_accept: ready got %b want 0", ready); else passCnt++;
    while (!resultValid && lat < 200) begin @(posedge clk); #1; lat++; end
    checkCnt++; if (lat != expLat(3'b110, r2b)) $display("FAIL b2b_second_latency: got %0d want %0d", lat, expLat(3'b110, r2b)); else passCnt++;
    checkCnt++; if (result !== mb[31:0]) $display("FAIL b2b_second_result: got %h want %h", result, mb[31:0]); else passCnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] res, rs1, rs2; logic [32:0] m; logic d, pOk; int lat, extra;
    runOp(3'b000, 32'd3, 32'd5, res, d, lat, pOk);
    checkCnt++; if (res !== 32'd15) $display("FAIL rstmid_pre_result: got %h want 0000000f", res); else passCnt++;
    @(posedge clk); #1;
    opCode = 3'b000; operand1 = condOp($urandom, 1'b1); operand0 = condOp($urandom, 1'b1); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checkCnt++; if (ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", ready); else passCnt++;
    checkCnt++; if (result !== 32'h0) $display("FAIL rstmid_result: got %h want 0", result); else passCnt++;
    checkCnt++; if (resultValid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", resultValid); else passCnt++;
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (resultValid) extra++; end
    checkCnt++; if (extra != 0) $display("FAIL rstmid_ghost_valid: got %0d want 0", extra); else passCnt++;
    rs1 = $urandom; rs2 = 32'($urandom_range(1, 1000));
    m = refModel(3'b100, rs1, rs2);
    runOp(3'b100, rs1, rs2, res, d, lat, pOk);
    checkCnt++; if (res !== m[31:0]) $display("FAIL rstmid_div_result: got %h want %h", res, m[31:0]); else passCnt++;
    checkCnt++; if (lat != 34) $display("FAIL rstmid_div_latency: got %0d want 34", lat); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/mul_div_sequencer.md
# mul_div_sequencer

Iterative radix-2 multiply/divide core for the Multiply-Division Unit. It consumes the 33-bit conditioned operands produced by the operand conditioning stages: operand0 is the multiplicand or divisor, operand1 is the multiplier or dividend. It produces the 32-bit RISC-V M-extension result selected by `opCode`. It sits directly downstream of operand conditioning and upstream of the writeback register.

## Interface
- `PAR`, 32, operand/result width
- `OPCODE_WIDTH`, 3, opcode width
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `start`  in  1  request; accepted only when `ready`=1
- `opCode`  in  OPCODE_WIDTH  encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `operand0`  in  PAR+1  conditioned multiplicand/divisor, 33-bit two's complement
- `operand1`  in  PAR+1  conditioned multiplier/dividend, 33-bit two's complement
- `ready`  out  1  high in IDLE
- `resultValid`  out  1  one-cycle pulse, result available
- `result`  out  PAR  result, held until next `resultValid`
- `divByZero`  out  1  qualified by `resultValid`; high for DIV/DIVU/REM/REMU with divisor 0

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE → MUL when `start`&`ready`&!opCode[2].
- IDLE → DIV when `start`&`ready`&opCode[2] and divisor ≠ 0.
- IDLE → FIX when `start`&`ready`&opCode[2] and divisor = 0.
- MUL → FIX after 33 iterations. DIV → FIX after 32 iterations. FIX → IDLE unconditionally.
- On accept, latch both operands and `opCode`. Inputs are don't-care afterwards.
- MUL path: both operands are treated as signed 33-bit values, giving a signed 66-bit product.
  - Shift-add, multiplier LSB first.
  - Iterations 0..31 add the multiplicand when the bit is set.
  - Iteration 32 (multiplier sign bit) subtracts the multiplicand.
  - Accumulator is 34 bits, sign-extended on shift.
  - MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32].
- DIV path:
  - Take 32-bit magnitudes of both operands; |x| ≤ 2^31 always fits.
  - Restoring division, one quotient bit per iteration, MSB first.
  - FIX negates the quotient if the operand signs differ, and negates the remainder if the dividend is negative.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Overflow 0x80000000 / −1 falls out naturally: quotient magnitude 2^31 negates to 0x80000000, remainder 0.
- Divide by zero: quotient 0xFFFFFFFF, remainder = operand1[31:0], `divByZero`=1.
- `start` while not ready is ignored. There is no queueing.

## Timing
- Reset values: state IDLE, `ready`=1, `resultValid`=0, `result`=0, `divByZero`=0, internal registers 0.
- Let E0 be the accepting edge. `ready` falls after E0.
- MUL: iterations on E1..E33; FIX registers result on E34. `resultValid` is high in the cycle after E34, i.e. 35 cycles after the `start` cycle.
- DIV: iterations on E1..E32; FIX on E33; 34-cycle latency.
- Divide by zero: FIX on E1; 2-cycle latency.
- `ready` rises together with `resultValid`. A new `start` in that same cycle is accepted, allowing back-to-back operation.
- `rst` asserted at any edge, including mid-iteration, overrides everything:
  - next cycle is IDLE with reset values;
  - `result` is cleared;
  - no `resultValid` for the aborted operation.
- `result` and `divByZero` change only on the FIX edge or on reset.

## Test plan
- MUL: operand0=7, operand1=−3 (0x1FFFFFFFD) → `result`=0xFFFFFFEB, `resultValid` exactly 35 cycles after the `start` cycle, single-cycle pulse.
- MULH with −1×−1 → 0x00000000. MULHU with operands zero-extended from 0xFFFFFFFF → 0xFFFFFFFE. MULHSU with rs1=−1, rs2=0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each with 34-cycle latency.
- Divisor 0: DIV with dividend 5 → 0xFFFFFFFF; REMU with dividend 0x12345678 → 0x12345678. Both show `divByZero`=1 and 2-cycle latency. DIV 0x80000000 / −1 → 0x80000000; REM of the same → 0.
- Handshake:
  - `start` pulsed during busy → ignored, result unchanged;
  - `start` held high through `resultValid` → second op accepted in the valid cycle;
  - operands changed after accept → result unaffected.
- `rst` asserted at iteration 10 of a MUL → next cycle `ready`=1, `result`=0, no `resultValid`. A following DIV completes correctly.
